// File: rtl/add_chain_pkg.sv
// Shared mode encoding and per-stage add helpers for the add_chain_pipe datapath.
// Optional ADD_CHAIN_SAT_EN switches every stage add from wrap-around to saturation.
package add_chain_pkg;

    typedef enum logic {
        MODE_STAGED    = 1'b0,
        MODE_COLLAPSED = 1'b1
    } mode_e;

    // Wide enough to hold in_data + (k+1)*STEP for any practical WIDTH/DEPTH
    localparam int unsigned CALC_W = 64;
    typedef logic [CALC_W-1:0] calc_t;

    function automatic calc_t width_max(int unsigned width);
        return (calc_t'(1) << width) - calc_t'(1);
    endfunction

    function automatic calc_t stage_add(calc_t a, calc_t step, int unsigned width);
        calc_t sum;
        sum = a + step;
`ifdef ADD_CHAIN_SAT_EN
        return (sum > width_max(width)) ? width_max(width) : sum;
`else
        return sum & width_max(width);
`endif
    endfunction

    function automatic logic stage_sat(calc_t a, calc_t step, int unsigned width);
        return (a + step) > width_max(width);
    endfunction

endpackage

// File: rtl/add_chain_stage.sv
// One add stage: register, valid bit and adder; load captures src+step, clear drops valid.
// With ADD_CHAIN_SAT_EN the stage also reports saturation on the cycle it loads.
module add_chain_stage
    import add_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] src_i,
    input  calc_t            step_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
`ifdef ADD_CHAIN_SAT_EN
    ,
    output logic             sat_o
`endif
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = WIDTH'(stage_add(calc_t'(src_i), step_i, WIDTH));
            valid_d = 1'b1;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

`ifdef ADD_CHAIN_SAT_EN
    assign sat_o = load_i && stage_sat(calc_t'(src_i), step_i, WIDTH);
`endif

endmodule

// File: rtl/add_chain_pipe.sv
// DEPTH-stage "+STEP" chain with valid/ready handshakes, run-time STAGED/COLLAPSED modes.
// Optional ADD_CHAIN_SAT_EN: saturating adds plus a sticky sat_flag output.
module add_chain_pipe
    import add_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned STEP  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DEPTH*WIDTH-1:0]     stage_q,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       active_mode
`ifdef ADD_CHAIN_SAT_EN
    ,
    output logic                       sat_flag
`endif
);

    localparam int unsigned      OCC_W  = $clog2(DEPTH+1);
    localparam logic [WIDTH-1:0] STEP_T = WIDTH'(STEP);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] clear;
    logic [WIDTH-1:0] d [DEPTH];
    mode_e            active_q, active_d;
    logic             mode_ok;
    logic             in_xfer;
    logic [OCC_W-1:0] occ;

    // Staged control walks from the sink back to the source so a pop at the
    // tail ripples forward and lets bubbles close up in the same cycle.
    always_comb begin
        load     = '0;
        clear    = '0;
        in_ready = 1'b0;
        mode_ok  = (mode_e'(mode) == active_q);
        if (active_q == MODE_STAGED) begin
            clear[DEPTH-1] = v[DEPTH-1] && out_ready;
            for (int unsigned i = DEPTH-1; i >= 1; i--) begin
                load[i]    = v[i-1] && (!v[i] || clear[i]);
                clear[i-1] = load[i];
            end
            in_ready = mode_ok && (!v[0] || clear[0]);
            load[0]  = in_valid && in_ready;
        end else begin
            in_ready = mode_ok && (!v[DEPTH-1] || out_ready);
            load     = {DEPTH{in_valid && in_ready}};
            clear    = {DEPTH{v[DEPTH-1] && out_ready}};
        end
        in_xfer = in_valid && in_ready;
    end

`ifdef ADD_CHAIN_SAT_EN
    logic [DEPTH-1:0] sat_hit;
    logic             sat_q, sat_d;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] src;
        calc_t            step;

        if (k == 0) begin : g_head
            assign src = in_data;
        end else begin : g_body
            assign src = (active_q == MODE_COLLAPSED) ? in_data : d[k-1];
        end

        assign step = (active_q == MODE_COLLAPSED) ? calc_t'(k+1) * calc_t'(STEP_T)
                                                   : calc_t'(STEP_T);

        add_chain_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk_i   (clk),
            .reset_ni(reset),
            .load_i  (load[k]),
            .clear_i (clear[k]),
            .src_i   (src),
            .step_i  (step),
            .data_o  (d[k]),
            .valid_o (v[k])
`ifdef ADD_CHAIN_SAT_EN
            ,
            .sat_o   (sat_hit[k])
`endif
        );

        assign stage_q[k*WIDTH +: WIDTH] = d[k];
    end

    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(v[i]);
        end
    end

    // Mode only changes with the chain empty, so in-flight data never sees both modes.
    always_comb begin
        active_d = active_q;
        if (occ == '0 && !in_xfer) begin
            active_d = mode_e'(mode);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= MODE_STAGED;
        end else begin
            active_q <= active_d;
        end
    end

`ifdef ADD_CHAIN_SAT_EN
    assign sat_d = sat_q || (|sat_hit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`endif

    assign out_valid   = v[DEPTH-1];
    assign out_data    = d[DEPTH-1];
    assign occupancy   = occ;
    assign active_mode = logic'(active_q);

endmodule

// File: tb/tb_add_chain_pipe.sv
// Directed bench for add_chain_pipe (WIDTH=8, DEPTH=3, STEP=1), both modes,
// wrap/saturation (ADD_CHAIN_SAT_EN), backpressure, mode switch and mid-run reset.
module tb_add_chain_pipe;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] stage_q;
    logic [1:0]  occupancy;
    logic        active_mode;
`ifdef ADD_CHAIN_SAT_EN
    logic        sat_flag;
    localparam logic [7:0]  EXP_ST_FE = 8'hFF;
    localparam logic [23:0] EXP_CO_FE = 24'hFFFFFF;
`else
    localparam logic [7:0]  EXP_ST_FE = 8'h01;
    localparam logic [23:0] EXP_CO_FE = 24'h0100FF;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    add_chain_pipe #(
        .WIDTH(8),
        .DEPTH(3),
        .STEP (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .stage_q    (stage_q),
        .occupancy  (occupancy),
        .active_mode(active_mode)
`ifdef ADD_CHAIN_SAT_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset     = 1'b0;
        mode      = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        chk("rst_occ",    32'(occupancy),   0);
        chk("rst_ovalid", 32'(out_valid),   0);
        chk("rst_odata",  32'(out_data),    0);
        chk("rst_stage",  32'(stage_q),     0);
        chk("rst_amode",  32'(active_mode), 0);
        reset = 1'b1;
        tick;

        // STAGED single sample: 5 -> 8 after 3 cycles
        in_data  = 8'd5;
        in_valid = 1'b1;
        #1 chk("st_in_ready", 32'(in_ready), 1);
        tick;
        in_valid = 1'b0;
        chk("st_lat1", 32'(out_valid), 0);
        tick;
        chk("st_lat2", 32'(out_valid), 0);
        tick;
        chk("st_lat3_valid", 32'(out_valid), 1);
        chk("st_lat3_data",  32'(out_data),  8);
        tick;
        chk("st_drain_valid", 32'(out_valid), 0);
        chk("st_drain_occ",   32'(occupancy), 0);

        // STAGED back-to-back 5,6,7 -> 8,9,10
        in_data  = 8'd5;
        in_valid = 1'b1;
        tick;
        in_data = 8'd6;
        tick;
        in_data = 8'd7;
        tick;
        in_valid = 1'b0;
        chk("b2b_stage", 32'(stage_q),   32'h080808);
        chk("b2b_occ",   32'(occupancy), 3);
        chk("b2b_out0",  32'(out_data),  8);
        tick;
        chk("b2b_out1_valid", 32'(out_valid), 1);
        chk("b2b_out1",       32'(out_data),  9);
        tick;
        chk("b2b_out2_valid", 32'(out_valid), 1);
        chk("b2b_out2",       32'(out_data),  10);
        tick;
        chk("b2b_empty", 32'(out_valid), 0);
`ifdef ADD_CHAIN_SAT_EN
        chk("sat_clear", 32'(sat_flag), 0);
`endif

        // STAGED boundary: 0xFE wraps to 0x01 (or saturates to 0xFF)
        in_data  = 8'hFE;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("st_fe_valid", 32'(out_valid), 1);
        chk("st_fe_data",  32'(out_data),  32'(EXP_ST_FE));
`ifdef ADD_CHAIN_SAT_EN
        chk("sat_set", 32'(sat_flag), 1);
`endif
        tick;

        // STAGED backpressure: 3 accepted, 4th stalls, then drains in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h10;
        tick;
        in_data = 8'h20;
        tick;
        in_data = 8'h30;
        tick;
        in_data = 8'h40;
        #1;
        chk("bp_in_ready", 32'(in_ready),  0);
        chk("bp_occ",      32'(occupancy), 3);
        chk("bp_ovalid",   32'(out_valid), 1);
        chk("bp_odata",    32'(out_data),  32'h13);
        tick;
        chk("bp_hold_data", 32'(out_data),  32'h13);
        chk("bp_hold_occ",  32'(occupancy), 3);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 1);
        tick;
        in_valid = 1'b0;
        chk("bp_out2", 32'(out_data), 32'h23);
        tick;
        chk("bp_out3", 32'(out_data), 32'h33);
        tick;
        chk("bp_out4_valid", 32'(out_valid), 1);
        chk("bp_out4",       32'(out_data),  32'h43);
        tick;
        chk("bp_empty", 32'(out_valid), 0);

        // Mode switch with two samples in flight
        in_data  = 8'd1;
        in_valid = 1'b1;
        tick;
        in_data = 8'd2;
        tick;
        in_valid = 1'b0;
        chk("ms_occ2", 32'(occupancy), 2);
        mode     = 1'b1;
        in_data  = 8'h50;
        in_valid = 1'b1;
        #1 chk("ms_block", 32'(in_ready), 0);
        tick;
        chk("ms_out1",   32'(out_data),    4);
        chk("ms_amode0", 32'(active_mode), 0);
        chk("ms_block2", 32'(in_ready),    0);
        tick;
        chk("ms_out2", 32'(out_data),  5);
        chk("ms_occ1", 32'(occupancy), 1);
        tick;
        chk("ms_drained", 32'(occupancy),   0);
        chk("ms_still0",  32'(active_mode), 0);
        chk("ms_block3",  32'(in_ready),    0);
        tick;
        chk("ms_amode1", 32'(active_mode), 1);
        chk("ms_ready",  32'(in_ready),    1);
        tick;
        chk("co_lat_valid", 32'(out_valid), 1);
        chk("co_lat_data",  32'(out_data),  32'h53);
        chk("co_lat_stage", 32'(stage_q),   32'h535251);
        chk("co_lat_occ",   32'(occupancy), 3);

        // COLLAPSED simultaneous pop and push of 5
        in_data = 8'd5;
        #1 chk("co_pp_ready", 32'(in_ready), 1);
        tick;
        in_valid = 1'b0;
        chk("co_pp_valid", 32'(out_valid), 1);
        chk("co_pp_data",  32'(out_data),  8);
        chk("co_pp_stage", 32'(stage_q),   32'h080706);
        tick;
        chk("co_empty_valid", 32'(out_valid), 0);
        chk("co_empty_occ",   32'(occupancy), 0);

        // COLLAPSED boundary 0xFE under backpressure
        out_ready = 1'b0;
        in_data   = 8'hFE;
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("co_fe_stage", 32'(stage_q), 32'(EXP_CO_FE));
        #1 chk("co_bp_ready", 32'(in_ready), 0);
        tick;
        chk("co_bp_hold", 32'(out_data), 32'(EXP_ST_FE));
        out_ready = 1'b1;
        tick;
        chk("co_bp_popped", 32'(out_valid), 0);

        // Back to STAGED, then reset with two samples in flight
        mode = 1'b0;
        tick;
        chk("back_staged", 32'(active_mode), 0);
        in_data  = 8'h11;
        in_valid = 1'b1;
        tick;
        in_data = 8'h22;
        tick;
        in_valid = 1'b0;
        chk("rm_occ2", 32'(occupancy), 2);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("rm_occ",    32'(occupancy),   0);
        chk("rm_ovalid", 32'(out_valid),   0);
        chk("rm_stage",  32'(stage_q),     0);
        chk("rm_amode",  32'(active_mode), 0);
`ifdef ADD_CHAIN_SAT_EN
        chk("rm_sat", 32'(sat_flag), 0);
`endif
        tick;
        tick;
        chk("rm_no_output", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
